sample_serializer: RTL and testbench

Serial DAC transmitter on the consuming side of the voice sample path. Accepts signed OUTPUT_BITS samples through a valid/ready handshake into a small FIFO and shifts them out MSB-first on a left-justified stereo serial link (dac_bclk/dac_lrclk/dac_sdata). The mono sample is duplicated into both channel slots. The link clocks are derived from main_clk by an internal divider.

---
 rtl/sample_serializer.sv | 117 +++++++++++
 tb/tb_sample_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sample_serializer.sv
// sample_serializer: sample FIFO feeding a left-justified stereo serial DAC link.
// Each mono sample is sent MSB-first in both the left and the right slot. The
// link clocks come from a main_clk divider, and all serial state moves on
// dac_bclk falling edges.
module sample_serializer #(
  parameter int OUTPUT_BITS = 12,
  parameter int FRAME_BITS  = 16,
  parameter int BCLK_DIV    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             main_clk,
  input  logic                             reset,
  input  logic signed [OUTPUT_BITS-1:0]    sample_in,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             dac_bclk,
  output logic                             dac_lrclk,
  output logic                             dac_sdata,
  output logic                             underrun
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(2*FRAME_BITS);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PAD = FRAME_BITS - OUTPUT_BITS;

  // FIFO storage and pointers
  logic [OUTPUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;

  // serial state
  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [OUTPUT_BITS-1:0] held;
  logic [FRAME_BITS-1:0]  shreg;

  logic                   wrap, fall, frame_start, right_start, push, pop;
  logic [BW-1:0]          bit_nxt;
  logic [OUTPUT_BITS-1:0] load_val;
  logic [FRAME_BITS-1:0]  frame_word, held_word;

  assign sample_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push         = sample_valid && sample_ready;

  assign wrap        = (div_cnt == DW'(BCLK_DIV-1));
  assign fall        = wrap && dac_bclk;
  assign bit_nxt     = (bit_cnt == BW'(2*FRAME_BITS-1)) ? '0 : bit_cnt + 1'b1;
  assign frame_start = fall && (bit_nxt == '0);
  assign right_start = fall && (bit_nxt == BW'(FRAME_BITS));
  // An empty FIFO is never bypassed: a same-cycle push lands in the FIFO only.
  assign pop         = frame_start && (fifo_level != '0);

  assign load_val   = pop ? mem[rd_ptr] : held;
  // Left-justify: sample in the top bits, zero padding below.
  assign frame_word = FRAME_BITS'(load_val) << PAD;
  assign held_word  = FRAME_BITS'(held) << PAD;

  // FIFO data array; contents need no reset because fifo_level gates reads
  always_ff @(posedge main_clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // FIFO pointers and exact occupancy count
  always_ff @(posedge main_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // bclk divider plus the frame/slot shifter, which moves only on bclk falls
  always_ff @(posedge main_clk) begin
    if (reset) begin
      div_cnt   <= '0;
      dac_bclk  <= 1'b0;
      bit_cnt   <= BW'(2*FRAME_BITS-1);
      held      <= '0;
      shreg     <= '0;
      dac_lrclk <= 1'b0;
      dac_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
      underrun <= 1'b0;
      if (wrap) dac_bclk <= ~dac_bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        if (frame_start) begin
          held      <= load_val;
          shreg     <= frame_word;
          dac_lrclk <= 1'b0;
          dac_sdata <= frame_word[FRAME_BITS-1];
          underrun  <= !pop;
        end else if (right_start) begin
          shreg     <= held_word;
          dac_lrclk <= 1'b1;
          dac_sdata <= held_word[FRAME_BITS-1];
        end else begin
          shreg     <= shreg << 1;
          dac_sdata <= shreg[FRAME_BITS-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer (OUTPUT_BITS=12, FRAME_BITS=16,
// BCLK_DIV=2, FIFO_DEPTH=4): one frame = 128 main_clk cycles.
module tb_sample_serializer;

  logic        main_clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        dac_bclk, dac_lrclk, dac_sdata, underrun;

  int vectors = 0;
  int miscompares = 0;

  sample_serializer #(
    .OUTPUT_BITS(12), .FRAME_BITS(16), .BCLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .main_clk    (main_clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fifo_level  (fifo_level),
    .dac_bclk    (dac_bclk),
    .dac_lrclk   (dac_lrclk),
    .dac_sdata   (dac_sdata),
    .underrun    (underrun)
  );

  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bclk"},  32'(dac_bclk),     32'd0);
    chk({tag, "_lrclk"}, 32'(dac_lrclk),    32'd0);
    chk({tag, "_sdata"}, 32'(dac_sdata),    32'd0);
    chk({tag, "_under"}, 32'(underrun),     32'd0);
    chk({tag, "_level"}, 32'(fifo_level),   32'd0);
    chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  // Called on a frame-start cycle; watches 128 cycles, collects both slots
  // and checks bclk/lrclk/underrun shape cycle by cycle. Optionally pushes
  // one sample during cycle offset push_off.
  task automatic frame(input string tag, input logic [15:0] exp_word, input logic exp_uf,
                       input int push_off, input logic [11:0] push_val);
    logic [15:0] l, r;
    int bad;
    l = '0; r = '0; bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (dac_bclk  !== ((k % 4) >= 2)) bad++;
      if (dac_lrclk !== (k >= 64)) bad++;
      if (underrun  !== ((k == 0) ? exp_uf : 1'b0)) bad++;
      if (k % 4 == 1) begin
        if (k < 64) l[15 - k/4] = dac_sdata;
        else        r[15 - (k-64)/4] = dac_sdata;
      end
      if (k == push_off) begin
        sample_valid = 1'b1;
        sample_in    = push_val;
      end
      tick;
      sample_valid = 1'b0;
    end
    chk({tag, "_left"},   32'(l),   32'(exp_word));
    chk({tag, "_right"},  32'(r),   32'(exp_word));
    chk({tag, "_timing"}, 32'(bad), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) tick;
    chk_reset("reset");

    // release: this cycle is cycle 0; push 800 then 7FF
    reset        = 1'b0;
    sample_valid = 1'b1;
    sample_in    = 12'h800;
    tick;                                   // cycle 1
    chk("bclk_c1", 32'(dac_bclk), 32'd0);
    chk("level_c1", 32'(fifo_level), 32'd1);
    sample_in = 12'h7FF;
    tick;                                   // cycle 2
    sample_valid = 1'b0;
    chk("bclk_rise", 32'(dac_bclk), 32'd1);
    chk("level_c2", 32'(fifo_level), 32'd2);
    tick;                                   // cycle 3: first fall event
    chk("bclk_c3", 32'(dac_bclk), 32'd1);
    tick;                                   // cycle 4: frame start
    chk("level_f1", 32'(fifo_level), 32'd1);
    frame("f1", 16'h8000, 1'b0, -1, 12'h0);
    chk("level_f2", 32'(fifo_level), 32'd0);
    frame("f2", 16'h7FF0, 1'b0, -1, 12'h0);

    // cycle 260: empty FIFO at frame start; then hold valid for 6 cycles
    chk("under_empty", 32'(underrun), 32'd1);
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_in    = 12'h101 + 12'(i);
      tick;
    end
    sample_valid = 1'b0;                    // cycle 266
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ready", 32'(sample_ready), 32'd0);
    repeat (121) tick;                      // cycle 387
    chk("pre_pop_ready", 32'(sample_ready), 32'd0);
    chk("pre_pop_level", 32'(fifo_level), 32'd4);
    tick;                                   // cycle 388: after pop
    chk("post_pop_ready", 32'(sample_ready), 32'd1);
    chk("post_pop_level", 32'(fifo_level), 32'd3);
    frame("f3", 16'h1010, 1'b0, -1, 12'h0);
    frame("f4", 16'h1020, 1'b0, -1, 12'h0);
    // level 1 here; push lands on the frame-start pop edge
    frame("f5", 16'h1030, 1'b0, 127, 12'h9AB);
    chk("level_samecycle", 32'(fifo_level), 32'd1);
    frame("f6", 16'h1040, 1'b0, -1, 12'h0);
    chk("level_f7", 32'(fifo_level), 32'd0);
    frame("f7", 16'h9AB0, 1'b0, -1, 12'h0);

    // cycle 1028: empty again; queue 3 samples then reset at bit_cnt=20
    chk("under_f8", 32'(underrun), 32'd1);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in    = 12'h311 + 12'(i);
      tick;
    end
    sample_valid = 1'b0;                    // cycle 1031
    repeat (77) tick;                       // cycle 1108
    chk("mid_level", 32'(fifo_level), 32'd3);
    chk("mid_lrclk", 32'(dac_lrclk), 32'd1);
    reset = 1'b1;
    tick;
    chk_reset("midreset");
    reset = 1'b0;                           // release: cycle 0
    chk("rel_bclk0", 32'(dac_bclk), 32'd0);
    tick;
    chk("rel_bclk1", 32'(dac_bclk), 32'd0);
    tick;
    chk("rel_bclk2", 32'(dac_bclk), 32'd1);
    tick;
    chk("rel_bclk3", 32'(dac_bclk), 32'd1);
    tick;                                   // cycle 4: frame start, FIFO flushed
    frame("r1", 16'h0000, 1'b1, -1, 12'h0);
    frame("r2", 16'h0000, 1'b1, 120, 12'h123);
    frame("r3", 16'h1230, 1'b0, -1, 12'h0);
    frame("r4", 16'h1230, 1'b1, -1, 12'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
